// File: rtl/pipe_defs.sv
// rtl/pipe_defs.sv - shared pipeline encodings: ALU ops, next-PC kinds, writeback selects
package pipe_defs;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'h00,
    ALU_SUB   = 5'h01,
    ALU_SLL   = 5'h02,
    ALU_SLT   = 5'h03,
    ALU_SLTU  = 5'h04,
    ALU_XOR   = 5'h05,
    ALU_SRL   = 5'h06,
    ALU_SRA   = 5'h07,
    ALU_OR    = 5'h08,
    ALU_AND   = 5'h09,
    ALU_LUI   = 5'h0A,
    ALU_AUIPC = 5'h0B,
    ALU_BEQ   = 5'h0C,
    ALU_BNE   = 5'h0D,
    ALU_BLT   = 5'h0E,
    ALU_BGE   = 5'h0F,
    ALU_BLTU  = 5'h10,
    ALU_BGEU  = 5'h11
  } alu_op_t;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JAL    = 3'd2,
    NPC_JALR   = 3'd4
  } npc_op_t;

  typedef enum logic [2:0] {
    WD_ALU = 3'd0,
    WD_MEM = 3'd1,
    WD_PC4 = 3'd2
  } wd_sel_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU; compare ops drive cond and leave result at zero
module alu
  import pipe_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      alu_op,
  output logic [XLEN-1:0] result,
  output logic            cond
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    cond   = 1'b0;
    case (alu_op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_LUI:   result = b;
      ALU_AUIPC: result = pc + b;
      ALU_BEQ:   cond = (a == b);
      ALU_BNE:   cond = (a != b);
      ALU_BLT:   cond = ($signed(a) < $signed(b));
      ALU_BGE:   cond = ($signed(a) >= $signed(b));
      ALU_BLTU:  cond = (a < b);
      ALU_BGEU:  cond = (a >= b);
      default:   ;
    endcase
  end

endmodule

// File: rtl/ex_stage_mem_reg.sv
// rtl/ex_stage_mem_reg.sv - EX stage (forwarding, ALU, branch resolve) plus EX/MEM register
module ex_stage_mem_reg
  import pipe_defs::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ID_EX_PC,
  input  logic [XLEN-1:0] ID_EX_read1_data,
  input  logic [XLEN-1:0] ID_EX_read2_data,
  input  logic [XLEN-1:0] ID_EX_imm,
  input  logic [4:0]      ID_EX_RS1,
  input  logic [4:0]      ID_EX_RS2,
  input  logic [4:0]      ID_EX_RD,
  input  logic            ID_EX_RegWrite,
  input  logic            ID_EX_MemWrite,
  input  logic            ID_EX_MemRead,
  input  logic            ID_EX_ALUSrc,
  input  logic [4:0]      ID_EX_ALUOp,
  input  logic [2:0]      ID_EX_NPCOp,
  input  logic [2:0]      ID_EX_WDSel,
  input  logic [2:0]      ID_EX_DMType,
  input  logic [4:0]      MEM_WB_RD,
  input  logic            MEM_WB_RegWrite,
  input  logic [XLEN-1:0] MEM_WB_wdata,
  input  logic            EX_stall,
  input  logic            EX_flush,
  output logic            EX_redirect,
  output logic [XLEN-1:0] EX_target,
  output logic [XLEN-1:0] EX_MEM_PC,
  output logic [XLEN-1:0] EX_MEM_aluout,
  output logic [XLEN-1:0] EX_MEM_store_data,
  output logic [4:0]      EX_MEM_RD,
  output logic            EX_MEM_RegWrite,
  output logic            EX_MEM_MemWrite,
  output logic            EX_MEM_MemRead,
  output logic [2:0]      EX_MEM_WDSel,
  output logic [2:0]      EX_MEM_DMType
);

  logic            ex_fwd_ok, wb_fwd_ok;
  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_result, jalr_sum, aluout_next;
  logic            alu_cond, take;

  // A load in EX/MEM has no data yet; the hazard unit has already stalled for that case.
  assign ex_fwd_ok = FWD_EN && EX_MEM_RegWrite && (EX_MEM_RD != 5'd0) && (EX_MEM_WDSel != WD_MEM);
  assign wb_fwd_ok = FWD_EN && MEM_WB_RegWrite && (MEM_WB_RD != 5'd0);

  always_comb begin
    fwd_a = ID_EX_read1_data;
    if (ex_fwd_ok && (EX_MEM_RD == ID_EX_RS1))      fwd_a = EX_MEM_aluout;
    else if (wb_fwd_ok && (MEM_WB_RD == ID_EX_RS1)) fwd_a = MEM_WB_wdata;
  end

  always_comb begin
    fwd_b = ID_EX_read2_data;
    if (ex_fwd_ok && (EX_MEM_RD == ID_EX_RS2))      fwd_b = EX_MEM_aluout;
    else if (wb_fwd_ok && (MEM_WB_RD == ID_EX_RS2)) fwd_b = MEM_WB_wdata;
  end

  assign alu_b = ID_EX_ALUSrc ? ID_EX_imm : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (fwd_a),
    .b      (alu_b),
    .pc     (ID_EX_PC),
    .alu_op (ID_EX_ALUOp),
    .result (alu_result),
    .cond   (alu_cond)
  );

  assign jalr_sum = fwd_a + ID_EX_imm;

  always_comb begin
    take      = 1'b0;
    EX_target = ID_EX_PC + ID_EX_imm;
    case (ID_EX_NPCOp)
      NPC_BRANCH: take = alu_cond;
      NPC_JAL:    take = 1'b1;
      NPC_JALR: begin
        take      = 1'b1;
        EX_target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default:    take = 1'b0;
    endcase
  end

  assign EX_redirect = take & ~EX_stall & ~EX_flush & ~rst;

  assign aluout_next = (ID_EX_WDSel == WD_PC4) ? (ID_EX_PC + XLEN'(4)) : alu_result;

  // Flush clears only what makes the slot architecturally visible; data fields are don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      EX_MEM_PC         <= '0;
      EX_MEM_aluout     <= '0;
      EX_MEM_store_data <= '0;
      EX_MEM_RD         <= '0;
      EX_MEM_RegWrite   <= 1'b0;
      EX_MEM_MemWrite   <= 1'b0;
      EX_MEM_MemRead    <= 1'b0;
      EX_MEM_WDSel      <= '0;
      EX_MEM_DMType     <= '0;
    end else if (EX_flush) begin
      EX_MEM_PC         <= ID_EX_PC;
      EX_MEM_aluout     <= aluout_next;
      EX_MEM_store_data <= fwd_b;
      EX_MEM_RD         <= '0;
      EX_MEM_RegWrite   <= 1'b0;
      EX_MEM_MemWrite   <= 1'b0;
      EX_MEM_MemRead    <= 1'b0;
      EX_MEM_WDSel      <= '0;
      EX_MEM_DMType     <= '0;
    end else if (!EX_stall) begin
      EX_MEM_PC         <= ID_EX_PC;
      EX_MEM_aluout     <= aluout_next;
      EX_MEM_store_data <= fwd_b;
      EX_MEM_RD         <= ID_EX_RD;
      EX_MEM_RegWrite   <= ID_EX_RegWrite;
      EX_MEM_MemWrite   <= ID_EX_MemWrite;
      EX_MEM_MemRead    <= ID_EX_MemRead;
      EX_MEM_WDSel      <= ID_EX_WDSel;
      EX_MEM_DMType     <= ID_EX_DMType;
    end
  end

endmodule

// File: tb/tb_ex_stage_mem_reg.sv
// tb/tb_ex_stage_mem_reg.sv - scoreboard bench for ex_stage_mem_reg against a behavioural model
module tb_ex_stage_mem_reg;

  logic        clk = 1'b0;
  logic        rst, EX_stall, EX_flush;
  logic [31:0] ID_EX_PC, ID_EX_read1_data, ID_EX_read2_data, ID_EX_imm, MEM_WB_wdata;
  logic [4:0]  ID_EX_RS1, ID_EX_RS2, ID_EX_RD, ID_EX_ALUOp, MEM_WB_RD;
  logic        ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_MemRead, ID_EX_ALUSrc, MEM_WB_RegWrite;
  logic [2:0]  ID_EX_NPCOp, ID_EX_WDSel, ID_EX_DMType;
  logic        EX_redirect;
  logic [31:0] EX_target, EX_MEM_PC, EX_MEM_aluout, EX_MEM_store_data;
  logic [4:0]  EX_MEM_RD;
  logic        EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemRead;
  logic [2:0]  EX_MEM_WDSel, EX_MEM_DMType;

  always #5 clk = ~clk;

  ex_stage_mem_reg #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_PC(ID_EX_PC), .ID_EX_read1_data(ID_EX_read1_data), .ID_EX_read2_data(ID_EX_read2_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2), .ID_EX_RD(ID_EX_RD),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_NPCOp(ID_EX_NPCOp),
    .ID_EX_WDSel(ID_EX_WDSel), .ID_EX_DMType(ID_EX_DMType),
    .MEM_WB_RD(MEM_WB_RD), .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_wdata(MEM_WB_wdata),
    .EX_stall(EX_stall), .EX_flush(EX_flush),
    .EX_redirect(EX_redirect), .EX_target(EX_target),
    .EX_MEM_PC(EX_MEM_PC), .EX_MEM_aluout(EX_MEM_aluout), .EX_MEM_store_data(EX_MEM_store_data),
    .EX_MEM_RD(EX_MEM_RD), .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_WDSel(EX_MEM_WDSel), .EX_MEM_DMType(EX_MEM_DMType)
  );

  typedef struct {
    logic rst, stall, flush;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0] rs1, rs2, rd, op;
    logic rw, mw, mr, alusrc;
    logic [2:0] npc, wd, dmt;
    logic [4:0] wbrd;
    logic wbrw;
    logic [31:0] wbdata;
    bit lit_alu;
    logic [31:0] lit_alu_v;
    bit lit_red;
    logic lit_red_v;
    logic [31:0] lit_tgt;
  } stim_t;

  typedef struct {
    logic [31:0] pc, alu, sd;
    logic [4:0] rd;
    logic rw, mw, mr;
    logic [2:0] wd, dmt;
  } em_t;

  typedef struct {
    logic red;
    logic [31:0] tgt;
    em_t em;
    bit lit_alu;
    logic [31:0] lit_alu_v;
    bit lit_red;
    logic lit_red_v;
    logic [31:0] lit_tgt;
  } exp_t;

  exp_t exp_q[$];
  em_t  m = '{default: '0};
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf, input stim_t s);
    if (m.rw && m.rd != 0 && m.rd == idx && m.wd != 3'd1) return m.alu;
    if (s.wbrw && s.wbrd != 0 && s.wbrd == idx) return s.wbdata;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] pc, output logic cond);
    int sa, sb;
    sa = a; sb = b; cond = 1'b0;
    case (op)
      5'h00: return a + b;
      5'h01: return a - b;
      5'h02: return a << b[4:0];
      5'h03: return (sa < sb) ? 32'd1 : 32'd0;
      5'h04: return (a < b) ? 32'd1 : 32'd0;
      5'h05: return a ^ b;
      5'h06: return a >> b[4:0];
      5'h07: return sa >>> b[4:0];
      5'h08: return a | b;
      5'h09: return a & b;
      5'h0A: return b;
      5'h0B: return pc + b;
      5'h0C: cond = (a == b);
      5'h0D: cond = (a != b);
      5'h0E: cond = (sa < sb);
      5'h0F: cond = (sa >= sb);
      5'h10: cond = (a < b);
      5'h11: cond = (a >= b);
      default: ;
    endcase
    return 32'd0;
  endfunction

  function automatic stim_t base();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = base();
    s.stall = ($urandom_range(0, 4) == 0);
    s.flush = ($urandom_range(0, 7) == 0);
    s.rst   = ($urandom_range(0, 49) == 0);
    s.pc = $urandom & 32'hFFFF_FFFC; s.r1 = $urandom; s.r2 = $urandom;
    s.imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 64));
    s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3)); s.rd = 5'($urandom_range(0, 3));
    s.op = 5'($urandom_range(0, 19)); s.npc = 3'($urandom_range(0, 7));
    s.wd = 3'($urandom_range(0, 3)); s.dmt = 3'($urandom_range(0, 7));
    s.rw = 1'($urandom); s.mw = 1'($urandom); s.mr = 1'($urandom); s.alusrc = 1'($urandom);
    s.wbrd = 5'($urandom_range(0, 3)); s.wbrw = 1'($urandom); s.wbdata = $urandom;
    return s;
  endfunction

  task automatic issue(input stim_t s);
    logic [31:0] a, b2, res;
    logic cond, take;
    exp_t e;
    em_t n;
    @(negedge clk);
    rst = s.rst; EX_stall = s.stall; EX_flush = s.flush;
    ID_EX_PC = s.pc; ID_EX_read1_data = s.r1; ID_EX_read2_data = s.r2; ID_EX_imm = s.imm;
    ID_EX_RS1 = s.rs1; ID_EX_RS2 = s.rs2; ID_EX_RD = s.rd; ID_EX_ALUOp = s.op;
    ID_EX_RegWrite = s.rw; ID_EX_MemWrite = s.mw; ID_EX_MemRead = s.mr; ID_EX_ALUSrc = s.alusrc;
    ID_EX_NPCOp = s.npc; ID_EX_WDSel = s.wd; ID_EX_DMType = s.dmt;
    MEM_WB_RD = s.wbrd; MEM_WB_RegWrite = s.wbrw; MEM_WB_wdata = s.wbdata;

    a   = fwd(s.rs1, s.r1, s);
    b2  = fwd(s.rs2, s.r2, s);
    res = alu_ref(s.op, a, s.alusrc ? s.imm : b2, s.pc, cond);
    take = (s.npc == 3'd1) ? cond : (s.npc == 3'd2 || s.npc == 3'd4);
    e.red = take && !s.stall && !s.flush && !s.rst;
    e.tgt = (s.npc == 3'd4) ? ((a + s.imm) & ~32'd1) : (s.pc + s.imm);

    n = '{pc: s.pc, alu: (s.wd == 3'd2) ? s.pc + 32'd4 : res, sd: b2, rd: s.rd,
          rw: s.rw, mw: s.mw, mr: s.mr, wd: s.wd, dmt: s.dmt};
    if (s.rst) n = '{default: '0};
    else if (s.flush) begin
      n.rd = 0; n.rw = 0; n.mw = 0; n.mr = 0; n.wd = 0; n.dmt = 0;
    end else if (s.stall) n = m;
    e.em = n;
    e.lit_alu = s.lit_alu; e.lit_alu_v = s.lit_alu_v;
    e.lit_red = s.lit_red; e.lit_red_v = s.lit_red_v; e.lit_tgt = s.lit_tgt;
    exp_q.push_back(e);
    m = n;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("redirect", 32'(EX_redirect), 32'(e.red));
        if (e.red) chk("target", EX_target, e.tgt);
        if (e.lit_red) begin
          chk("dir_redirect", 32'(EX_redirect), 32'(e.lit_red_v));
          if (e.lit_red_v) chk("dir_target", EX_target, e.lit_tgt);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("pc", EX_MEM_PC, e.em.pc);
        chk("aluout", EX_MEM_aluout, e.em.alu);
        chk("store_data", EX_MEM_store_data, e.em.sd);
        chk("rd", 32'(EX_MEM_RD), 32'(e.em.rd));
        chk("ctrl", {29'd0, EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemRead}, {29'd0, e.em.rw, e.em.mw, e.em.mr});
        chk("wdsel_dmtype", {26'd0, EX_MEM_WDSel, EX_MEM_DMType}, {26'd0, e.em.wd, e.em.dmt});
        if (e.lit_alu) chk("dir_aluout", EX_MEM_aluout, e.lit_alu_v);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    rst = 1'b1; EX_stall = 0; EX_flush = 0;
    ID_EX_PC = 0; ID_EX_read1_data = 0; ID_EX_read2_data = 0; ID_EX_imm = 0;
    ID_EX_RS1 = 0; ID_EX_RS2 = 0; ID_EX_RD = 0; ID_EX_ALUOp = 0;
    ID_EX_RegWrite = 0; ID_EX_MemWrite = 0; ID_EX_MemRead = 0; ID_EX_ALUSrc = 0;
    ID_EX_NPCOp = 0; ID_EX_WDSel = 0; ID_EX_DMType = 0;
    MEM_WB_RD = 0; MEM_WB_RegWrite = 0; MEM_WB_wdata = 0;

    for (int i = 0; i < 2; i++) begin
      s = rnd(); s.rst = 1; s.npc = 3'd2; s.lit_red = 1; s.lit_red_v = 0;
      issue(s);
    end

    s = base(); s.rs1 = 1; s.rs2 = 2; s.r1 = 5; s.r2 = 7; s.rd = 3; s.rw = 1;
    s.lit_alu = 1; s.lit_alu_v = 12; issue(s);
    s = base(); s.op = 5'h01; s.rs1 = 3; s.rs2 = 1; s.r1 = 0; s.r2 = 5; s.rd = 4; s.rw = 1;
    s.lit_alu = 1; s.lit_alu_v = 7; issue(s);

    s = base(); s.rs1 = 10; s.rs2 = 11; s.r1 = 4; s.r2 = 5; s.rd = 5; s.rw = 1; issue(s);
    s = base(); s.rs1 = 5; s.rd = 6; s.rw = 1; s.wbrd = 5; s.wbrw = 1; s.wbdata = 4;
    s.lit_alu = 1; s.lit_alu_v = 9; issue(s);
    s = base(); s.rs1 = 10; s.rs2 = 11; s.r1 = 100; s.rd = 0; s.rw = 1; issue(s);
    s = base(); s.r1 = 1; s.r2 = 2; s.rd = 6; s.rw = 1; s.wbrd = 0; s.wbrw = 1; s.wbdata = 77;
    s.lit_alu = 1; s.lit_alu_v = 3; issue(s);

    s = base(); s.op = 5'h0E; s.npc = 3'd1; s.rs1 = 20; s.rs2 = 21; s.r1 = 32'hFFFF_FFFF; s.r2 = 1;
    s.pc = 32'h100; s.imm = 32'h20; s.lit_red = 1; s.lit_red_v = 1; s.lit_tgt = 32'h120;
    s.lit_alu = 1; s.lit_alu_v = 0; issue(s);
    s.op = 5'h10; s.lit_red_v = 0; issue(s);

    s = base(); s.alusrc = 1; s.rs1 = 22; s.r1 = 32'h203; s.npc = 3'd4; s.wd = 3'd2; s.pc = 32'h40;
    s.rw = 1; s.rd = 1; s.lit_red = 1; s.lit_red_v = 1; s.lit_tgt = 32'h202;
    s.lit_alu = 1; s.lit_alu_v = 32'h44; issue(s);

    s = base(); s.alusrc = 1; s.rs1 = 23; s.r1 = 32'h1000; s.imm = 8; s.mr = 1; s.rw = 1; s.rd = 7;
    s.wd = 3'd1; s.lit_alu = 1; s.lit_alu_v = 32'h1008; issue(s);
    for (int i = 0; i < 3; i++) begin
      s = rnd(); s.rst = 0; s.flush = 0; s.stall = 1; s.lit_alu = 1; s.lit_alu_v = 32'h1008;
      issue(s);
    end
    s = rnd(); s.rst = 0; s.stall = 1; s.flush = 1; s.npc = 3'd2; s.lit_red = 1; s.lit_red_v = 0;
    issue(s);

    for (int i = 0; i < 400; i++) issue(rnd());

    repeat (4) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
